pc_sequencer: RTL

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer_if.sv | 47 ++++
 rtl/pc_sequencer.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if
// Groups the program-counter sequencing bus between a core (master) and the
// PC sequencer (slave). Signal prefixes are from the sequencer's point of view.
//   i_pc_cur         current PC register value
//   i_stall          hold the PC this cycle
//   i_branch_taken   redirect to i_branch_target
//   i_branch_target  redirect / call destination
//   i_call, i_ret    subroutine call / return requests
//   i_halt, i_resume enter / leave the halted state
//   o_pc_next        value loaded into the PC when o_pc_enable is high
//   o_pc_enable      PC register load enable
//   o_flush          bubble cycle following a redirect
//   o_halted         high while halted
//   o_ras_overflow   sticky: call pushed onto a full return-address stack
//   o_ras_underflow  sticky: return requested with an empty stack
interface pc_sequencer_if #(
  parameter int BITSIZE = 11
);
  logic [BITSIZE-1:0] i_pc_cur;
  logic               i_stall;
  logic               i_branch_taken;
  logic [BITSIZE-1:0] i_branch_target;
  logic               i_call;
  logic               i_ret;
  logic               i_halt;
  logic               i_resume;
  logic [BITSIZE-1:0] o_pc_next;
  logic               o_pc_enable;
  logic               o_flush;
  logic               o_halted;
  logic               o_ras_overflow;
  logic               o_ras_underflow;

  modport master (
    output i_pc_cur, i_stall, i_branch_taken, i_branch_target,
           i_call, i_ret, i_halt, i_resume,
    input  o_pc_next, o_pc_enable, o_flush, o_halted,
           o_ras_overflow, o_ras_underflow
  );

  modport slave (
    input  i_pc_cur, i_stall, i_branch_taken, i_branch_target,
           i_call, i_ret, i_halt, i_resume,
    output o_pc_next, o_pc_enable, o_flush, o_halted,
           o_ras_overflow, o_ras_underflow
  );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer
// Computes the next program-counter value and its load enable each cycle,
// handling stalls, branches, call/return through a circular return-address
// stack (RAS), a one-cycle flush bubble after every redirect, and halt/resume.
// Ports:
//   clk    clock, all state updates on the rising edge
//   reset  synchronous active-high reset
//   bus    pc_sequencer_if slave modport (see the interface for signal list)
module pc_sequencer #(
  parameter int BITSIZE   = 11,
  parameter int RAS_DEPTH = 4
) (
  input logic           clk,
  input logic           reset,
  pc_sequencer_if.slave bus
);

  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(RAS_DEPTH);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;
  localparam logic [1:0] ST_HALT  = 2'd3;

  logic [1:0]         r_state;
  logic [1:0]         w_state_next;

  logic [BITSIZE-1:0] r_ras [RAS_DEPTH];
  logic [PTR_W-1:0]   r_ptr;
  logic [PTR_W:0]     r_count;
  logic               r_overflow;
  logic               r_underflow;

  logic [PTR_W-1:0]   w_top_idx;
  logic [BITSIZE-1:0] w_top;
  logic [BITSIZE-1:0] w_pc_inc;
  logic               w_ras_empty;
  logic               w_push;
  logic               w_pop;
  logic               w_underflow_set;

  logic [BITSIZE-1:0] w_pc_next;
  logic               w_pc_enable;
  logic               w_flush;
  logic               w_halted;

  // r_ptr always points at the next free slot, so the top of stack sits one
  // below it. Once the stack is full the pointer has wrapped onto the oldest
  // entry, which is exactly the slot a further push should overwrite.
  assign w_top_idx   = r_ptr - PTR_W'(1);
  assign w_top       = r_ras[w_top_idx];
  assign w_pc_inc    = bus.i_pc_cur + BITSIZE'(1);
  assign w_ras_empty = (r_count == '0);

  // Next-state and output decode. Outputs default to "hold the PC" so every
  // path with pc_enable low also presents pc_next equal to pc_cur.
  always_comb begin
    w_state_next    = r_state;
    w_pc_next       = bus.i_pc_cur;
    w_pc_enable     = 1'b0;
    w_flush         = 1'b0;
    w_halted        = 1'b0;
    w_push          = 1'b0;
    w_pop           = 1'b0;
    w_underflow_set = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_state_next = ST_RUN;
      end

      ST_RUN: begin
        if (bus.i_halt) begin
          w_state_next = ST_HALT;
        end else if (bus.i_ret) begin
          if (!w_ras_empty) begin
            w_pc_next    = w_top;
            w_pc_enable  = 1'b1;
            w_pop        = 1'b1;
            w_state_next = ST_FLUSH;
          end else begin
            // A return with nothing to return to degrades to a plain step.
            w_underflow_set = 1'b1;
            w_pc_next       = w_pc_inc;
            w_pc_enable     = 1'b1;
          end
        end else if (bus.i_call) begin
          w_push       = 1'b1;
          w_pc_next    = bus.i_branch_target;
          w_pc_enable  = 1'b1;
          w_state_next = ST_FLUSH;
        end else if (bus.i_branch_taken) begin
          w_pc_next    = bus.i_branch_target;
          w_pc_enable  = 1'b1;
          w_state_next = ST_FLUSH;
        end else if (!bus.i_stall) begin
          w_pc_next   = w_pc_inc;
          w_pc_enable = 1'b1;
        end
      end

      ST_FLUSH: begin
        w_flush      = 1'b1;
        w_state_next = bus.i_halt ? ST_HALT : ST_RUN;
      end

      ST_HALT: begin
        w_halted = 1'b1;
        if (bus.i_resume) begin
          w_state_next = ST_RUN;
        end
      end

      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Stack pointer, occupancy and sticky error flags. A push onto a full
  // stack keeps the count saturated and only raises the overflow flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr       <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_ptr <= r_ptr + PTR_W'(1);
        if (r_count == FULL_COUNT) begin
          r_overflow <= 1'b1;
        end else begin
          r_count <= r_count + (PTR_W + 1)'(1);
        end
      end else if (w_pop) begin
        r_ptr   <= w_top_idx;
        r_count <= r_count - (PTR_W + 1)'(1);
      end
      if (w_underflow_set) begin
        r_underflow <= 1'b1;
      end
    end
  end

  // Stack storage carries no reset; entries are only read when counted valid.
  always_ff @(posedge clk) begin
    if (w_push && !reset) begin
      r_ras[r_ptr] <= w_pc_inc;
    end
  end

  assign bus.o_pc_next       = w_pc_next;
  assign bus.o_pc_enable     = w_pc_enable;
  assign bus.o_flush         = w_flush;
  assign bus.o_halted        = w_halted;
  assign bus.o_ras_overflow  = r_overflow;
  assign bus.o_ras_underflow = r_underflow;

endmodule
